miriscv_rf: RTL and testbench

MIRISCV_RF -- requirements
Module: miriscv_rf

---
 rtl/miriscv_rf_pkg.sv | 29 ++
 rtl/miriscv_rf.sv | 92 +++++++++
 tb/tb_miriscv_rf.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/miriscv_rf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : miriscv_rf_pkg
//  Description : Shared constants for the miriscv register file. Holds the
//                default data width, address width and register count, and
//                the address of the hard-wired zero register (x0).
//  Revision    : 1.0 - initial release
// ============================================================================
package miriscv_rf_pkg;

    // Default data width of every register and data port.
    localparam int DEF_XLEN  = 32;

    // Default register address width.
    localparam int DEF_AW    = 5;

    // Default number of architectural registers; always 2**DEF_AW.
    localparam int DEF_NREGS = 32;

    // Address of x0. It always reads zero and ignores writes.
    localparam int ZERO_REG  = 0;

    // Returns 1 when an address selects the hard-wired zero register.
    function automatic logic is_zero_reg(input logic [DEF_AW-1:0] addr);
        return (addr == DEF_AW'(ZERO_REG));
    endfunction

endpackage : miriscv_rf_pkg
`default_nettype wire

// File: rtl/miriscv_rf.sv
`default_nettype none
// ============================================================================
//  Module      : miriscv_rf
//  Description : Two-read / one-write integer register file for the miriscv
//                core. Reads are purely combinational with no write-to-read
//                bypass. The write port updates on the rising edge of clk_i.
//                x0 is hard-wired to zero. The synchronous active-high reset
//                clears every register and takes priority over a concurrent
//                write.
//
//  Ports
//    clk_i    in   1     clock; all state updates occur on the rising edge
//    addr1_i  in   AW    read port 1 address
//    addr2_i  in   AW    read port 2 address
//    addr3_i  in   AW    write port address
//    wd_i     in   XLEN  write data
//    we_i     in   1     write enable (active-high)
//    reset    in   1     synchronous, active-high reset
//    rd1_o    out  XLEN  read data selected by addr1_i
//    rd2_o    out  XLEN  read data selected by addr2_i
//
//  Revision    : 1.0 - initial release
// ============================================================================
module miriscv_rf
    import miriscv_rf_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int NREGS = DEF_NREGS,
    parameter int AW    = DEF_AW     // NREGS must equal 2**AW
) (
    input  logic            clk_i,
    input  logic [AW-1:0]   addr1_i,
    input  logic [AW-1:0]   addr2_i,
    input  logic [AW-1:0]   addr3_i,
    input  logic [XLEN-1:0] wd_i,
    input  logic            we_i,
    input  logic            reset,
    output logic [XLEN-1:0] rd1_o,
    output logic [XLEN-1:0] rd2_o
);

    localparam logic [AW-1:0] c_zero_addr = AW'(ZERO_REG);

    // ------------------------------------------------------------------------
    // Storage. Entry 0 is cleared by reset and never written. The read muxes
    // also force it to zero, so x0 reads zero even before the first reset.
    // ------------------------------------------------------------------------
    logic [XLEN-1:0] r_regs [NREGS];

    // One-hot write select. Bit 0 can never be set, which drops writes to x0.
    logic [NREGS-1:0] w_wr_sel;

    always_comb begin
        w_wr_sel = '0;
        if (we_i && (addr3_i != c_zero_addr)) begin
            w_wr_sel[addr3_i] = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Register update. Reset wins over a write in the same cycle, so a
    // register addressed during reset still ends up zero.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (w_wr_sel[i]) begin
                    r_regs[i] <= wd_i;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read muxes. These have no bypass: a read of the register being written
    // returns the old contents until the write edge has passed.
    // ------------------------------------------------------------------------
    logic w_rd1_zero;
    logic w_rd2_zero;

    assign w_rd1_zero = (addr1_i == c_zero_addr);
    assign w_rd2_zero = (addr2_i == c_zero_addr);

    assign rd1_o = w_rd1_zero ? '0 : r_regs[addr1_i];
    assign rd2_o = w_rd2_zero ? '0 : r_regs[addr2_i];

endmodule : miriscv_rf
`default_nettype wire

// File: tb/tb_miriscv_rf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_miriscv_rf
//  Description : Directed self-checking bench for miriscv_rf
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_miriscv_rf;

    logic        clk_i;
    logic [4:0]  addr1_i;
    logic [4:0]  addr2_i;
    logic [4:0]  addr3_i;
    logic [31:0] wd_i;
    logic        we_i;
    logic        reset;
    logic [31:0] rd1_o;
    logic [31:0] rd2_o;

    int errors = 0;
    int checks = 0;

    logic [31:0] vals [32];

    miriscv_rf dut (
        .clk_i   (clk_i),
        .addr1_i (addr1_i),
        .addr2_i (addr2_i),
        .addr3_i (addr3_i),
        .wd_i    (wd_i),
        .we_i    (we_i),
        .reset   (reset),
        .rd1_o   (rd1_o),
        .rd2_o   (rd2_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Advance one rising edge, then settle 1ns before anything is sampled.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        addr1_i = '0; addr2_i = '0; addr3_i = '0;
        wd_i    = '0; we_i    = 1'b0; reset   = 1'b1;

        // Reset state.
        tick();
        addr1_i = 5'd1; addr2_i = 5'd31; #1;
        chk("reset_rd1_x1", rd1_o, 32'h0);
        chk("reset_rd2_x31", rd2_o, 32'h0);
        reset = 1'b0;

        // Write x1 = 6. Before the edge the read must still show the old
        // value because there is no bypass.
        we_i = 1'b1; addr3_i = 5'd1; wd_i = 32'd6; addr1_i = 5'd1; #1;
        chk("no_bypass_before_edge", rd1_o, 32'h0);
        tick();
        chk("write_x1", rd1_o, 32'd6);

        addr3_i = 5'd2;  addr1_i = 5'd2;  tick(); chk("write_x2",  rd1_o, 32'd6);
        addr3_i = 5'd4;  addr1_i = 5'd4;  tick(); chk("write_x4",  rd1_o, 32'd6);
        addr3_i = 5'd15; addr1_i = 5'd15; tick(); chk("write_x15", rd1_o, 32'd6);
        we_i = 1'b0;

        // Unwritten register is still zero.
        addr1_i = 5'd3; #1;
        chk("unwritten_x3", rd1_o, 32'h0);

        // Both ports read simultaneously.
        addr1_i = 5'd1; addr2_i = 5'd2; #1;
        chk("dual_rd1_x1", rd1_o, 32'd6);
        chk("dual_rd2_x2", rd2_o, 32'd6);

        // Same register on both ports.
        addr1_i = 5'd15; addr2_i = 5'd15; #1;
        chk("same_rd1_x15", rd1_o, 32'd6);
        chk("same_rd2_x15", rd2_o, 32'd6);

        // we=0 blocks writes.
        we_i = 1'b0; addr3_i = 5'd1; wd_i = 32'd15; addr1_i = 5'd1;
        tick(); tick(); tick();
        chk("we0_hold_x1", rd1_o, 32'd6);

        // Writes to x0 are ignored.
        we_i = 1'b1; addr3_i = 5'd0; wd_i = 32'd6; addr1_i = 5'd0; addr2_i = 5'd0;
        tick();
        chk("x0_rd1", rd1_o, 32'h0);
        chk("x0_rd2", rd2_o, 32'h0);
        we_i = 1'b0;

        // Reset clears the registers that were written.
        reset = 1'b1; tick(); reset = 1'b0;
        addr1_i = 5'd1;  addr2_i = 5'd2;  #1;
        chk("rst_clr_rd1_x1", rd1_o, 32'h0);
        chk("rst_clr_rd2_x2", rd2_o, 32'h0);
        addr1_i = 5'd4;  addr2_i = 5'd15; #1;
        chk("rst_clr_rd1_x4", rd1_o, 32'h0);
        chk("rst_clr_rd2_x15", rd2_o, 32'h0);

        // Reset has priority over a concurrent write.
        reset = 1'b1; we_i = 1'b1; addr3_i = 5'd5; wd_i = 32'hFFFF_FFFF;
        addr1_i = 5'd5; addr2_i = 5'd5;
        tick();
        chk("rst_prio_rd1_x5", rd1_o, 32'h0);
        chk("rst_prio_rd2_x5", rd2_o, 32'h0);
        reset = 1'b0; we_i = 1'b0; #1;
        chk("rst_prio_after_x5", rd1_o, 32'h0);

        // Fill x1..x31 with distinct values. The register number sits in the
        // top byte, which keeps every value unique.
        for (int i = 1; i < 32; i++) begin
            vals[i] = {i[7:0], 24'($urandom())};
            we_i = 1'b1; addr3_i = i[4:0]; wd_i = vals[i];
            tick();
        end
        we_i = 1'b0;
        for (int i = 1; i < 32; i++) begin
            addr1_i = i[4:0]; addr2_i = 5'(32 - i); #1;
            chk($sformatf("fill_rd1_x%0d", i), rd1_o, vals[i]);
            chk($sformatf("fill_rd2_x%0d", 32 - i), rd2_o, vals[32 - i]);
        end
        addr1_i = 5'd0; addr2_i = 5'd0; #1;
        chk("fill_x0_rd1", rd1_o, 32'h0);
        chk("fill_x0_rd2", rd2_o, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_miriscv_rf
`default_nettype wire
